// File: rtl/forwarding_hazard_unit_pkg.sv
// forwarding_hazard_unit_pkg: selector encoding shared by the forwarding unit and its encoder
package forwarding_hazard_unit_pkg;
  localparam int FWD_SEL_REGFILE = 0;
endpackage

// File: rtl/forwarding_hazard_unit_priority_encoder.sv
// forwarding_priority_encoder: nearest-first match of one operand against the tracking pipeline
module forwarding_priority_encoder
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int AW = 5,
  parameter int N  = 2,
  parameter int SW = 2,
  parameter int LL = 1
) (
  input  logic [AW-1:0]        reg_addr,
  input  logic [N-1:0][AW-1:0] dest,
  input  logic [N-1:0]         we,
  input  logic [N-1:0]         load,
  output logic [SW-1:0]        selector,
  output logic                 load_hazard
);
  always_comb begin
    selector = SW'(FWD_SEL_REGFILE);
    load_hazard = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (we[k] && dest[k] == reg_addr && reg_addr != '0) begin
        selector = SW'(N - k);
        load_hazard = load_hazard | (load[k] && k < LL);
      end
    end
  end
endmodule

// File: rtl/forwarding_hazard_unit.sv
// forwarding_hazard_unit: N-deep forwarding selectors, load-use stall and saturating stall counter
module forwarding_hazard_unit
  import forwarding_hazard_unit_pkg::*;
#(
  parameter int CANT_BITS_ADDR_REGISTROS = 5,
  parameter int CANT_ETAPAS_FWD          = 2,
  parameter int CANT_BITS_SELECTOR_MUX   = 2,
  parameter int LOAD_LATENCY             = 1,
  parameter int CANT_BITS_CONTADOR       = 32
) (
  input  logic                                i_clock,
  input  logic                                i_soft_reset,
  input  logic                                i_enable,
  input  logic                                i_flush,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rs_id,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rt_id,
  input  logic [CANT_BITS_ADDR_REGISTROS-1:0] i_rd_id,
  input  logic                                i_reg_write_id,
  input  logic                                i_mem_read_id,
  input  logic                                i_clear_contador,
  output logic [CANT_BITS_SELECTOR_MUX-1:0]   o_selector_mux_A,
  output logic [CANT_BITS_SELECTOR_MUX-1:0]   o_selector_mux_B,
  output logic                                o_stall,
  output logic [CANT_BITS_CONTADOR-1:0]       o_cant_stalls
);
  localparam int AW = CANT_BITS_ADDR_REGISTROS;
  localparam int N  = CANT_ETAPAS_FWD;
  localparam int SW = CANT_BITS_SELECTOR_MUX;
  logic [N-1:0][AW-1:0] t_dest;
  logic [N-1:0]         t_we;
  logic [N-1:0]         t_load;
  logic [SW-1:0]        sel_a, sel_b;
  logic                 haz_a, haz_b, bubble;
  forwarding_priority_encoder #(.AW(AW), .N(N), .SW(SW), .LL(LOAD_LATENCY)) u_fwd_rs (
    .reg_addr(i_rs_id), .dest(t_dest), .we(t_we), .load(t_load),
    .selector(sel_a), .load_hazard(haz_a)
  );
  forwarding_priority_encoder #(.AW(AW), .N(N), .SW(SW), .LL(LOAD_LATENCY)) u_fwd_rt (
    .reg_addr(i_rt_id), .dest(t_dest), .we(t_we), .load(t_load),
    .selector(sel_b), .load_hazard(haz_b)
  );
  // a flushed ID instruction never stalls, it is simply replaced by a bubble
  assign o_stall = !i_flush && (haz_a || haz_b);
  assign bubble  = i_flush || o_stall;
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      t_dest <= '0;
      t_we <= '0;
      t_load <= '0;
      o_selector_mux_A <= SW'(FWD_SEL_REGFILE);
      o_selector_mux_B <= SW'(FWD_SEL_REGFILE);
    end else if (i_enable) begin
      for (int k = N - 1; k > 0; k--) begin
        t_dest[k] <= t_dest[k-1];
        t_we[k] <= t_we[k-1];
        t_load[k] <= t_load[k-1];
      end
      t_dest[0] <= bubble ? '0 : i_rd_id;
      t_we[0] <= !bubble && i_reg_write_id;
      t_load[0] <= !bubble && i_mem_read_id;
      o_selector_mux_A <= bubble ? SW'(FWD_SEL_REGFILE) : sel_a;
      o_selector_mux_B <= bubble ? SW'(FWD_SEL_REGFILE) : sel_b;
    end
  end
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) o_cant_stalls <= '0;
    else if (i_clear_contador) o_cant_stalls <= '0;
    else if (i_enable && o_stall && !(&o_cant_stalls)) o_cant_stalls <= o_cant_stalls + 1'b1;
  end
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// tb_forwarding_hazard_unit: directed table, corner sequences and random run against a queue model
module tb_forwarding_hazard_unit;
  logic clk = 0, rst_n, en, fl, clr, we, ld;
  logic [4:0] rs, rt, rd;
  logic [1:0] a2, b2, a3, b3;
  logic st2, st3;
  logic [31:0] c2;
  logic [2:0] c3;
  int checks = 0, errors = 0;
  bit chk_on = 0;
  always #5 clk = ~clk;

  forwarding_hazard_unit dut2 (
    .i_clock(clk), .i_soft_reset(rst_n), .i_enable(en), .i_flush(fl),
    .i_rs_id(rs), .i_rt_id(rt), .i_rd_id(rd), .i_reg_write_id(we), .i_mem_read_id(ld),
    .i_clear_contador(clr), .o_selector_mux_A(a2), .o_selector_mux_B(b2),
    .o_stall(st2), .o_cant_stalls(c2)
  );
  forwarding_hazard_unit #(.CANT_ETAPAS_FWD(3), .LOAD_LATENCY(2), .CANT_BITS_CONTADOR(3)) dut3 (
    .i_clock(clk), .i_soft_reset(rst_n), .i_enable(en), .i_flush(fl),
    .i_rs_id(rs), .i_rt_id(rt), .i_rd_id(rd), .i_reg_write_id(we), .i_mem_read_id(ld),
    .i_clear_contador(clr), .o_selector_mux_A(a3), .o_selector_mux_B(b3),
    .o_stall(st3), .o_cant_stalls(c3)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: each instance keeps a queue of in-flight {dest, we, load}, index 0 = EX.
  typedef struct packed {logic [4:0] d; logic w; logic l;} ent_t;
  ent_t q[2][$];
  int ns[2] = '{2, 3};
  int lls[2] = '{1, 2};
  longint cmax[2] = '{64'hFFFF_FFFF, 7};
  int ms_a[2], ms_b[2];
  longint mc[2];

  function automatic int sel_of(input ent_t qq[$], input logic [4:0] r);
    for (int k = 0; k < qq.size(); k++)
      if (qq[k].w && qq[k].d == r && r != 0) return qq.size() - k;
    return 0;
  endfunction

  function automatic bit haz_of(input ent_t qq[$], input int ll, input logic [4:0] r);
    for (int k = 0; k < ll && k < qq.size(); k++)
      if (qq[k].w && qq[k].l && qq[k].d == r && r != 0) return 1;
    return 0;
  endfunction

  function automatic bit m_stall(input int i);
    return !fl && (haz_of(q[i], lls[i], rs) || haz_of(q[i], lls[i], rt));
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      q[i].delete();
      for (int k = 0; k < ns[i]; k++) q[i].push_back('0);
      ms_a[i] = 0;
      ms_b[i] = 0;
      mc[i] = 0;
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset();
      else for (int i = 0; i < 2; i++) begin
        bit s, b;
        int na, nb;
        s = m_stall(i);
        b = fl || s;
        na = sel_of(q[i], rs);
        nb = sel_of(q[i], rt);
        if (clr) mc[i] = 0;
        else if (en && s && mc[i] < cmax[i]) mc[i]++;
        if (en) begin
          q[i].push_front(b ? ent_t'('0) : ent_t'({rd, we, ld}));
          void'(q[i].pop_back());
          ms_a[i] = b ? 0 : na;
          ms_b[i] = b ? 0 : nb;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && chk_on) for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_stall_n%0d", ns[i]), i ? st3 : st2, m_stall(i));
      chk($sformatf("model_sel_a_n%0d", ns[i]), i ? a3 : a2, ms_a[i]);
      chk($sformatf("model_sel_b_n%0d", ns[i]), i ? b3 : b2, ms_b[i]);
      chk($sformatf("model_cnt_n%0d", ns[i]), i ? c3 : c2, mc[i]);
    end
  end

  typedef struct {
    bit en, fl, clr;
    logic [4:0] rs, rt, rd;
    bit we, ld, e_st;
    int e_a, e_b, e_c;
  } vec_t;
  vec_t tbl[18];

  task automatic step(input bit e, f, c, input logic [4:0] s, t, d, input bit w, l);
    en = e; fl = f; clr = c; rs = s; rt = t; rd = d; we = w; ld = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl = '{
      '{1,0,0, 1,2, 3,1,0, 0, 0,0,0},
      '{1,0,0, 3,0, 6,1,0, 0, 2,0,0},
      '{1,0,0, 3,7, 8,1,0, 0, 1,0,0},
      '{1,0,0, 0,0, 5,1,0, 0, 0,0,0},
      '{1,0,0, 0,0, 5,1,0, 0, 0,0,0},
      '{1,0,0, 5,5, 0,1,0, 0, 2,2,0},
      '{1,0,0, 0,0, 9,0,0, 0, 0,0,0},
      '{1,0,0, 9,9, 4,1,1, 0, 0,0,0},
      '{1,0,0, 1,4,10,1,0, 1, 0,0,1},
      '{1,0,0, 1,4,10,1,0, 0, 0,1,1},
      '{1,0,0, 0,0, 4,1,1, 0, 0,0,1},
      '{1,1,0,10,4, 3,1,0, 0, 0,0,1},
      '{1,0,1, 4,0, 0,0,0, 0, 1,0,0},
      '{1,0,0, 0,0, 7,1,1, 0, 0,0,0},
      '{0,0,0, 0,7, 2,1,0, 1, 0,0,0},
      '{1,0,0, 7,7, 2,1,0, 1, 0,0,1},
      '{1,0,0, 7,7, 2,1,0, 0, 1,1,1},
      '{0,0,0, 2,0, 0,0,0, 0, 1,1,1}
    };
    rst_n = 0; en = 0; fl = 0; clr = 0; rs = 1; rt = 1; rd = 1; we = 1; ld = 1;
    #3;
    chk("reset_sel_a", a2, 0);
    chk("reset_sel_b", b2, 0);
    chk("reset_cnt", c2, 0);
    chk("reset_stall", st2, 0);
    chk("reset_stall_n3", st3, 0);
    #9 rst_n = 1;
    chk_on = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 18; i++) begin
      en = tbl[i].en; fl = tbl[i].fl; clr = tbl[i].clr;
      rs = tbl[i].rs; rt = tbl[i].rt; rd = tbl[i].rd; we = tbl[i].we; ld = tbl[i].ld;
      @(negedge clk);
      chk($sformatf("row%0d_stall", i), st2, tbl[i].e_st);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_sel_a", i), a2, tbl[i].e_a);
      chk($sformatf("row%0d_sel_b", i), b2, tbl[i].e_b);
      chk($sformatf("row%0d_cnt", i), c2, tbl[i].e_c);
    end
    rst_n = 0;
    #1;
    chk("async_rst_sel_a", a2, 0);
    chk("async_rst_sel_b", b2, 0);
    chk("async_rst_cnt", c2, 0);
    chk("async_rst_sel_a_n3", a3, 0);
    chk("async_rst_cnt_n3", c3, 0);
    @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1;
    step(1,0,0, 0,0,6,1,0);
    step(1,0,0, 0,0,0,0,0);
    step(1,0,0, 0,0,0,0,0);
    step(1,0,0, 6,0,6,1,0);
    chk("n3_match_t2", a3, 1);
    step(1,0,0, 6,0,0,0,0);
    chk("n3_match_t0", a3, 3);
    step(1,0,1, 0,0,0,0,0);
    repeat (5) begin
      step(1,0,0, 0,0,1,1,1);
      repeat (3) step(1,0,0, 1,0,2,1,0);
    end
    chk("n3_cnt_saturated", c3, 7);
    chk("n2_cnt_five_loads", c2, 5);
    repeat (400) begin
      en = ($urandom % 8) != 0;
      fl = ($urandom % 8) == 0;
      clr = ($urandom % 32) == 0;
      rs = 5'($urandom % 8);
      rt = 5'($urandom % 8);
      rd = 5'($urandom % 8);
      we = ($urandom % 4) != 0;
      ld = ($urandom % 3) == 0;
      @(posedge clk);
      #1;
    end
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/forwarding_hazard_unit.md
# forwarding_hazard_unit

Parametrised forwarding and load-use hazard unit for the MIPS pipeline, sitting between the ID/EX boundary and the EX-stage operand muxes. It tracks the destination register, write-enable and load flag of every in-flight instruction past ID in an internal N-deep pipeline. It produces registered, priority-resolved forwarding selectors for the instruction entering EX, and a load-use stall request. Compared with the fixed two-source unit, it adds configurable forwarding depth, register-$0 suppression, load-use stall generation, flush handling and a stall counter for the debug unit.

## Interface
- CANT_BITS_ADDR_REGISTROS, 5, register address width
- CANT_ETAPAS_FWD, 2, N = number of forwarding sources after EX (2 = MEM, WB)
- CANT_BITS_SELECTOR_MUX, 2, selector width; must be >= clog2(N+1)
- LOAD_LATENCY, 1, number of sources (nearest first) unable to supply load data; range 0..N-1
- CANT_BITS_CONTADOR, 32, stall counter width

- i_clock  input  1  system clock, rising edge
- i_soft_reset  input  1  asynchronous, active-low reset
- i_enable  input  1  pipeline advance (debug/step control); no state change when 0
- i_flush  input  1  kill the ID instruction (taken branch/jump)
- i_rs_id, i_rt_id  input  CANT_BITS_ADDR_REGISTROS  source registers of the ID instruction
- i_rd_id  input  CANT_BITS_ADDR_REGISTROS  resolved destination of the ID instruction
- i_reg_write_id  input  1  ID instruction writes the register file
- i_mem_read_id  input  1  ID instruction is a load
- i_clear_contador  input  1  synchronous clear of the stall counter
- o_selector_mux_A, o_selector_mux_B  output  CANT_BITS_SELECTOR_MUX  registered selectors for the EX instruction
- o_stall  output  1  combinational; freeze PC and IF/ID, insert bubble
- o_cant_stalls  output  CANT_BITS_CONTADOR  saturating count of stall cycles

## Operation
- Tracking pipeline t[0..N-1], each entry holding {dest, we, load}. t[0] is the instruction in EX; t[k] is k stages past EX.
- Match of operand r against t[k]: t[k].we=1, t[k].dest==r, r!=0.
- Selector for operand r:
  - Selector = N−k for the smallest matching k.
  - Selector = 0 (register file) if nothing matches.
  - With N=2: MEM=2, WB=1, normal=0.
- o_stall = !i_flush AND (i_rs_id or i_rt_id matches some t[k] with t[k].load=1 and k < LOAD_LATENCY).
- Advancing edge (i_enable=1), in order:
  - The tracking pipeline shifts: t[k] <= t[k−1]; t[N−1] is discarded.
  - If i_flush or o_stall: a bubble enters, t[0] <= {0,0,0}, and both selectors <= 0.
  - Otherwise: t[0] <= {i_rd_id, i_reg_write_id, i_mem_read_id}, and the selectors register the computed values.
- Counter: on an advancing edge with o_stall=1, o_cant_stalls increments, saturating at all-ones. i_clear_contador=1 sets it to 0 and has priority over the increment.
- Flush and a load-use condition together: flush wins; no stall, bubble inserted, counter unchanged.
- Stalled instruction: it remains on the ID inputs, and hazard detection repeats each cycle until the load has reached stage index >= LOAD_LATENCY.

## Timing
- Reset (asynchronous, i_soft_reset=0): all t[k]={0,0,0}, selectors 0, o_cant_stalls 0. o_stall is therefore 0 after reset regardless of ID inputs.
- Release of reset is synchronous to i_clock; the first advancing edge after release behaves normally.
- Selector latency: 1 cycle. Values computed from ID inputs at edge n are valid for the whole EX cycle n..n+1.
- o_stall: zero latency from ID inputs and the tracking state; it is not gated by i_enable.
- i_enable=0: tracking state, selectors and counter all hold.
- Load-use, N=2, LOAD_LATENCY=1: exactly one stall cycle. The dependent instruction then enters EX with selector 1 (WB).
- LOAD_LATENCY=0: o_stall is constantly 0.

## Structure
- Shared include file for the selector encoding: FWD_SEL_REGFILE=0. Sources are numbered N down to 1, nearest first.
- One sub-module, forwarding_priority_encoder: combinational, compares one operand against all N entries and returns {selector, load_hazard}. It is instantiated for rs and for rt.
- The top level holds the tracking pipeline, the selector registers, the stall logic and the counter.

## Test plan
- Back-to-back ALU dependency, N=2:
  - add $3 into EX, then sub using rs=$3 enters at the next edge -> o_selector_mux_A=2, B=0.
  - One instruction of separation -> A=1.
- Double match priority: t[0].dest=t[1].dest=$5, both writing, ID rs=rt=$5 -> A=B=2.
- Register $0: t[0]={dest 0, we 1}, ID rs=0 -> A=0.
- Load-use: lw $4 in t[0], ID rt=$4 -> o_stall=1 for exactly one cycle, o_cant_stalls 0->1. The next edge registers B=1.
- Flush during a load-use condition: i_flush=1 -> o_stall=0, bubble inserted, selectors 0, counter unchanged.
- Async reset mid-operation: i_soft_reset pulled low between edges -> selectors and counter read 0 immediately. N=3 instance: match at t[2] gives selector 1, match at t[0] gives selector 3.
